// File: rtl/axi_lite_status_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_status_regs
//
// AXI4-Lite responder giving the JTAG-to-AXI master a small register file
// next to the DDR3 controller: ID, DDR3 lock/calibration status with a sticky
// calibration-loss flag, a 16-bit CONTROL register driven to fabric logic, a
// free-running cycle counter and an optional 16 x 32 scratch RAM.
//
// Register map (byte offsets, bits [1:0] of the address ignored):
//   0x000 ID       RO  ID_VALUE
//   0x004 STATUS   bit0 locked_s, bit1 ready_s, bit2 calib_lost (W1C)
//   0x008 CONTROL  RW  bits [15:0], byte strobes [1:0] honoured
//   0x00C COUNTER  RO  free-running cycle counter
//   0x100-0x13C    SCRATCH (only when AXI_REGS_SCRATCH_EN is defined)
// Unmapped accesses return SLVERR (reads return 0).
//
// Build option: define AXI_REGS_SCRATCH_EN to build the scratch RAM. When it
// is undefined, the scratch window behaves as unmapped space.
//
// Ports:
//   clk, reset             fabric clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*        AXI4-Lite write channels
//   s_axi_ar*/r*           AXI4-Lite read channels
//   ddr3_locked/ddr3_ready asynchronous status inputs from the MIG
//   control                CONTROL register contents
//
// Handshake rule: a transfer happens on a rising clk edge where both valid
// and ready are high; a valid, once raised, holds its payload stable until
// that edge, and the responder's bvalid/rvalid drop on that same edge.
// ---------------------------------------------------------------------------
module axi_lite_status_regs #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] ID_VALUE   = 32'h4152_5459
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  ddr3_locked,
    input  logic                  ddr3_ready,
    output logic [15:0]           control
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] A_MASK    = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(12'h000);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(12'h004);
    localparam logic [ADDR_WIDTH-1:0] A_CONTROL = ADDR_WIDTH'(12'h008);
    localparam logic [ADDR_WIDTH-1:0] A_COUNTER = ADDR_WIDTH'(12'h00C);

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_DATA
    } rd_state_t;

    // ------------------------------------------------------------------
    // Status synchronizers and calibration-loss flag
    // ------------------------------------------------------------------
    logic r_locked_meta, r_locked_s;
    logic r_ready_meta, r_ready_s, r_ready_d;
    logic r_calib_lost;
    logic [15:0] r_control;
    logic [31:0] r_counter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_locked_meta <= 1'b0;
            r_locked_s    <= 1'b0;
            r_ready_meta  <= 1'b0;
            r_ready_s     <= 1'b0;
            r_ready_d     <= 1'b0;
        end else begin
            r_locked_meta <= ddr3_locked;
            r_locked_s    <= r_locked_meta;
            r_ready_meta  <= ddr3_ready;
            r_ready_s     <= r_ready_meta;
            r_ready_d     <= r_ready_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= 32'h0;
        end else begin
            r_counter <= r_counter + 32'h1;
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t             r_wr_state, w_wr_next;
    logic                  r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_bresp;
    logic                  w_awready, w_wready, w_commit;

    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_wr_status, w_wr_control, w_wr_ro, w_wr_scratch, w_wr_err;

    assign w_wr_addr    = r_awaddr & A_MASK;
    assign w_wr_status  = (w_wr_addr == A_STATUS);
    assign w_wr_control = (w_wr_addr == A_CONTROL);
    assign w_wr_ro      = (w_wr_addr == A_ID) || (w_wr_addr == A_COUNTER);
    assign w_wr_err     = !(w_wr_status || w_wr_control || w_wr_ro || w_wr_scratch);

    // Address and data are captured independently; the commit happens one
    // cycle after the later of the two lands, so the register update and
    // bvalid appear on the same edge.
    always_comb begin
        w_wr_next = r_wr_state;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_commit  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_awready = !r_aw_held;
                w_wready  = !r_w_held;
                if (r_aw_held && r_w_held) begin
                    w_commit  = 1'b1;
                    w_wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    w_wr_next = WR_IDLE;
                end
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= 32'h0;
            r_wstrb    <= 4'h0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            if (s_axi_awvalid && w_awready) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axi_awaddr;
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end
            if (s_axi_wvalid && w_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end
            if (w_commit) begin
                r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // A falling ready_s sets the flag; the W1C clear loses to a same-cycle set.
    logic w_lost_set, w_lost_clr;
    assign w_lost_set = r_ready_d && !r_ready_s;
    assign w_lost_clr = w_commit && w_wr_status && r_wstrb[0] && r_wdata[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_control    <= 16'h0;
            r_calib_lost <= 1'b0;
        end else begin
            if (w_commit && w_wr_control) begin
                if (r_wstrb[0]) r_control[7:0]  <= r_wdata[7:0];
                if (r_wstrb[1]) r_control[15:8] <= r_wdata[15:8];
            end
            if (w_lost_set) begin
                r_calib_lost <= 1'b1;
            end else if (w_lost_clr) begin
                r_calib_lost <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t             r_rd_state, w_rd_next;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic                  w_arready;

    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_rd_scratch, w_rd_err;
    logic [31:0]           w_scratch_rdata, w_rd_data;

    assign w_rd_addr = r_araddr & A_MASK;

    always_comb begin
        w_rd_data = 32'h0;
        w_rd_err  = 1'b0;
        if (w_rd_addr == A_ID) begin
            w_rd_data = ID_VALUE;
        end else if (w_rd_addr == A_STATUS) begin
            w_rd_data = {29'h0, r_calib_lost, r_ready_s, r_locked_s};
        end else if (w_rd_addr == A_CONTROL) begin
            w_rd_data = {16'h0, r_control};
        end else if (w_rd_addr == A_COUNTER) begin
            w_rd_data = r_counter;
        end else if (w_rd_scratch) begin
            w_rd_data = w_scratch_rdata;
        end else begin
            w_rd_err = 1'b1;
        end
    end

    // RD_LOAD is the cycle between the AR handshake and the data capture, so
    // a write committing on the capture edge is not yet visible to the read.
    always_comb begin
        w_rd_next = r_rd_state;
        w_arready = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                w_arready = 1'b1;
                if (s_axi_arvalid) begin
                    w_rd_next = RD_LOAD;
                end
            end
            RD_LOAD: w_rd_next = RD_DATA;
            RD_DATA: begin
                if (s_axi_rready) begin
                    w_rd_next = RD_IDLE;
                end
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
            r_araddr   <= '0;
            r_rdata    <= 32'h0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            if (s_axi_arvalid && w_arready) begin
                r_araddr <= s_axi_araddr;
            end
            if (r_rd_state == RD_LOAD) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scratch RAM (contents intentionally not reset)
    // ------------------------------------------------------------------
`ifdef AXI_REGS_SCRATCH_EN
    logic [31:0] r_scratch [16];

    assign w_wr_scratch    = (w_wr_addr[ADDR_WIDTH-1:6] == (ADDR_WIDTH-6)'(4));
    assign w_rd_scratch    = (w_rd_addr[ADDR_WIDTH-1:6] == (ADDR_WIDTH-6)'(4));
    assign w_scratch_rdata = r_scratch[w_rd_addr[5:2]];

    always_ff @(posedge clk) begin
        if (w_commit && w_wr_scratch) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_scratch[w_wr_addr[5:2]][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end
`else
    logic w_unused_wr;

    assign w_wr_scratch    = 1'b0;
    assign w_rd_scratch    = 1'b0;
    assign w_scratch_rdata = 32'h0;
    // Upper data bytes and strobes only matter to the scratch RAM.
    assign w_unused_wr     = &{1'b0, r_wdata[31:16], r_wstrb[3:2]};
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_awready = w_awready;
    assign s_axi_wready  = w_wready;
    assign s_axi_bvalid  = (r_wr_state == WR_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = w_arready;
    assign s_axi_rvalid  = (r_rd_state == RD_DATA);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign control       = r_control;

endmodule

// File: tb/tb_axi_lite_status_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_status_regs
//
// Directed bench for axi_lite_status_regs. Inputs are driven and outputs are
// sampled on the falling clock edge; handshakes complete on the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_status_regs;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata = 32'h0;
    logic [3:0]    s_axi_wstrb = 4'h0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;
    logic          ddr3_locked = 1'b1;
    logic          ddr3_ready = 1'b1;
    logic [15:0]   control;

    int checks = 0;
    int failures = 0;

    axi_lite_status_regs #(
        .ADDR_WIDTH (AW),
        .ID_VALUE   (32'h4152_5459)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .ddr3_locked   (ddr3_locked),
        .ddr3_ready    (ddr3_ready),
        .control       (control)
    );

    // ---------------- clock / watchdog ----------------
    always #2.5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (observed=running expected=finished)");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers (called on a falling edge) ----------------
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int   n;
        logic a_hs, w_hs;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 50) begin
            a_hs = s_axi_awvalid && s_axi_awready;
            w_hs = s_axi_wvalid && s_axi_wready;
            @(negedge clk);
            n++;
            if (a_hs) s_axi_awvalid = 1'b0;
            if (w_hs) s_axi_wvalid = 1'b0;
        end
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wr_done_in_time", {31'h0, s_axi_bvalid}, 32'd1);
        resp = s_axi_bresp;
        @(negedge clk);
        s_axi_bready  = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        logic a_hs;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arvalid && n < 50) begin
            a_hs = s_axi_arready;
            @(negedge clk);
            n++;
            if (a_hs) s_axi_arvalid = 1'b0;
        end
        s_axi_rready = 1'b1;
        while (!s_axi_rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_done_in_time", {31'h0, s_axi_rvalid}, 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        @(negedge clk);
        s_axi_rready  = 1'b0;
        s_axi_arvalid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd, rd2;
        logic [1:0]  rr, br;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_awready", {31'h0, s_axi_awready}, 32'd1);
        check("rst_wready",  {31'h0, s_axi_wready},  32'd1);
        check("rst_arready", {31'h0, s_axi_arready}, 32'd1);
        check("rst_bvalid",  {31'h0, s_axi_bvalid},  32'd0);
        check("rst_rvalid",  {31'h0, s_axi_rvalid},  32'd0);
        check("rst_bresp",   {30'h0, s_axi_bresp},   32'd0);
        check("rst_rresp",   {30'h0, s_axi_rresp},   32'd0);
        check("rst_rdata",   s_axi_rdata,            32'd0);
        check("rst_control", {16'h0, control},       32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // ID
        axi_read(12'h000, rd, rr);
        check("id_rdata", rd, 32'h4152_5459);
        check("id_rresp", {30'h0, rr}, 32'd0);

        // Counter: AR handshakes exactly 5 cycles apart
        axi_read(12'h00C, rd, rr);
        repeat (2) @(negedge clk);
        axi_read(12'h00C, rd2, rr);
        check("counter_delta", rd2 - rd, 32'd5);
        check("counter_rresp", {30'h0, rr}, 32'd0);

        // W three cycles ahead of AW on CONTROL, only byte 0 strobed
        s_axi_wdata  = 32'hFFFF_1234;
        s_axi_wstrb  = 4'b0001;
        s_axi_wvalid = 1'b1;
        check("w_first_wready", {31'h0, s_axi_wready}, 32'd1);
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        check("w_held_wready",  {31'h0, s_axi_wready},  32'd0);
        check("w_held_awready", {31'h0, s_axi_awready}, 32'd1);
        repeat (2) @(negedge clk);
        s_axi_awaddr  = 12'h008;
        s_axi_awvalid = 1'b1;
        check("aw_late_awready", {31'h0, s_axi_awready}, 32'd1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check("aw_late_bvalid_n", {31'h0, s_axi_bvalid}, 32'd0);
        @(negedge clk);
        check("aw_late_bvalid_n1", {31'h0, s_axi_bvalid}, 32'd1);
        check("aw_late_bresp",     {30'h0, s_axi_bresp},  32'd0);
        check("aw_late_control",   {16'h0, control},      32'h0000_0034);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("aw_late_bvalid_done", {31'h0, s_axi_bvalid}, 32'd0);
        axi_read(12'h008, rd, rr);
        check("control_readback", rd, 32'h0000_0034);

        // RO write ignored with OKAY; unmapped write/read get SLVERR
        axi_write(12'h000, 32'hDEAD_BEEF, 4'hF, br);
        check("ro_write_bresp", {30'h0, br}, 32'd0);
        axi_read(12'h000, rd, rr);
        check("ro_write_id_kept", rd, 32'h4152_5459);
        axi_write(12'h200, 32'h1234_5678, 4'hF, br);
        check("unmapped_bresp", {30'h0, br}, 32'd2);
        axi_read(12'h200, rd, rr);
        check("unmapped_rresp", {30'h0, rr}, 32'd2);
        check("unmapped_rdata", rd, 32'd0);

        // STATUS and calibration loss
        axi_read(12'h004, rd, rr);
        check("status_steady", rd, 32'h3);
        ddr3_ready = 1'b0;
        repeat (6) @(negedge clk);
        ddr3_ready = 1'b1;
        repeat (6) @(negedge clk);
        axi_read(12'h004, rd, rr);
        check("status_lost_set", rd, 32'h7);
        axi_write(12'h004, 32'h4, 4'b1110, br);
        axi_read(12'h004, rd, rr);
        check("status_clr_no_strb0", rd, 32'h7);
        axi_write(12'h004, 32'h4, 4'b0001, br);
        check("status_clr_bresp", {30'h0, br}, 32'd0);
        axi_read(12'h004, rd, rr);
        check("status_lost_cleared", rd, 32'h3);
        // ready_s falls two edges later, the flag sets on the third edge,
        // which is also the commit edge of a write presented one cycle later
        ddr3_ready = 1'b0;
        @(negedge clk);
        axi_write(12'h004, 32'h4, 4'b0001, br);
        axi_read(12'h004, rd, rr);
        check("status_set_wins", rd, 32'h5);
        ddr3_ready = 1'b1;
        repeat (6) @(negedge clk);
        axi_write(12'h004, 32'h4, 4'b0001, br);
        axi_read(12'h004, rd, rr);
        check("status_final", rd, 32'h3);

        // Scratch window
        axi_write(12'h104, 32'hA5A5_A5A5, 4'hF, br);
`ifdef AXI_REGS_SCRATCH_EN
        check("scratch_bresp", {30'h0, br}, 32'd0);
        axi_read(12'h104, rd, rr);
        check("scratch_rdata", rd, 32'hA5A5_A5A5);
        check("scratch_rresp", {30'h0, rr}, 32'd0);
        axi_write(12'h104, 32'h1122_3344, 4'b0101, br);
        axi_read(12'h104, rd, rr);
        check("scratch_strobe", rd, 32'hA522_A544);
`else
        check("scratch_bresp", {30'h0, br}, 32'd2);
        axi_read(12'h104, rd, rr);
        check("scratch_rdata", rd, 32'd0);
        check("scratch_rresp", {30'h0, rr}, 32'd2);
`endif

        // Concurrent write and read of CONTROL, then both responses stalled.
        // The write commits on the read's capture edge, so the read sees 0x34.
        s_axi_awaddr  = 12'h008;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = 32'h0000_BEEF;
        s_axi_wstrb   = 4'b0011;
        s_axi_wvalid  = 1'b1;
        s_axi_araddr  = 12'h008;
        s_axi_arvalid = 1'b1;
        check("conc_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("stall_bvalid",  {31'h0, s_axi_bvalid},  32'd1);
            check("stall_bresp",   {30'h0, s_axi_bresp},   32'd0);
            check("stall_rvalid",  {31'h0, s_axi_rvalid},  32'd1);
            check("stall_rdata",   s_axi_rdata,            32'h0000_0034);
            check("stall_rresp",   {30'h0, s_axi_rresp},   32'd0);
            check("stall_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
            @(negedge clk);
        end
        check("conc_control", {16'h0, control}, 32'h0000_BEEF);

        // Reset with a write in RESP and a read in DATA
        reset = 1'b1;
        @(negedge clk);
        check("midrst_bvalid",  {31'h0, s_axi_bvalid}, 32'd0);
        check("midrst_rvalid",  {31'h0, s_axi_rvalid}, 32'd0);
        check("midrst_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        check("midrst_control", {16'h0, control},      32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        axi_read(12'h008, rd, rr);
        check("post_rst_control", rd, 32'd0);
        axi_write(12'h008, 32'h0000_5A5A, 4'b0011, br);
        check("post_rst_control_wr", {16'h0, control}, 32'h0000_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
